// File: rtl/param_sequence_detector.sv
// Serial bit-pattern detector with run-time programmable pattern, length and overlap mode.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_COUNT_EN.
module param_sequence_detector #(
  parameter int                       PATTERN_WIDTH   = 5,
  parameter logic [PATTERN_WIDTH-1:0] DEFAULT_PATTERN = 5'b10110,
  parameter int                       COUNT_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               seq,
  input  logic                               valid,
  input  logic                               cfg_load,
  input  logic [PATTERN_WIDTH-1:0]           cfg_pattern,
  input  logic [$clog2(PATTERN_WIDTH+1)-1:0] cfg_len,
  input  logic                               cfg_overlap,
  output logic                               cfg_err,
  output logic                               detected,
  output logic [COUNT_WIDTH-1:0]             match_count
);

  localparam int LEN_WIDTH = $clog2(PATTERN_WIDTH + 1);
  localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(PATTERN_WIDTH);

  logic [PATTERN_WIDTH-1:0] hist_r;
  logic [LEN_WIDTH-1:0]     fill_r;
  logic [PATTERN_WIDTH-1:0] pattern_r;
  logic [LEN_WIDTH-1:0]     len_r;
  logic                     overlap_r;
  logic                     detected_r;
  logic                     cfg_err_r;

  logic [PATTERN_WIDTH-1:0] hist_next_s;
  logic [LEN_WIDTH-1:0]     fill_inc_s;
  logic [PATTERN_WIDTH-1:0] mask_s;
  logic                     match_s;
  logic                     cfg_ok_s;
  logic                     beat_s;

  // Next-beat history, saturating fill and match against the active-length window.
  always_comb begin
    hist_next_s = {hist_r[PATTERN_WIDTH-2:0], seq};
    if (fill_r >= FULL_LEN) begin
      fill_inc_s = FULL_LEN;
    end else begin
      fill_inc_s = fill_r + LEN_WIDTH'(1);
    end
    mask_s = '0;
    for (int i = 0; i < PATTERN_WIDTH; i++) begin
      mask_s[i] = (LEN_WIDTH'(i) < len_r);
    end
    match_s  = (fill_inc_s >= len_r) && (((hist_next_s ^ pattern_r) & mask_s) == '0);
    cfg_ok_s = (cfg_len != '0) && (cfg_len <= FULL_LEN);
    beat_s   = valid && !cfg_load;
  end

  // Config load has priority over a same-cycle beat; the beat is simply dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hist_r     <= '0;
      fill_r     <= '0;
      pattern_r  <= DEFAULT_PATTERN;
      len_r      <= FULL_LEN;
      overlap_r  <= 1'b1;
      detected_r <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else if (cfg_load) begin
      detected_r <= 1'b0;
      if (cfg_ok_s) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
        overlap_r <= cfg_overlap;
        hist_r    <= '0;
        fill_r    <= '0;
        cfg_err_r <= 1'b0;
      end else begin
        cfg_err_r <= 1'b1;
      end
    end else begin
      cfg_err_r <= 1'b0;
      if (valid) begin
        hist_r     <= hist_next_s;
        fill_r     <= (match_s && !overlap_r) ? LEN_WIDTH'(0) : fill_inc_s;
        detected_r <= match_s;
      end else begin
        detected_r <= 1'b0;
      end
    end
  end

  assign detected = detected_r;
  assign cfg_err  = cfg_err_r;

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_r;

  // Count moves on the same edge that raises detected, so it already includes that pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_r <= '0;
    end else if (cfg_load && cfg_ok_s) begin
      count_r <= '0;
    end else if (beat_s && match_s && (count_r != {COUNT_WIDTH{1'b1}})) begin
      count_r <= count_r + COUNT_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign match_count = count_r;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed self-checking bench for param_sequence_detector (COUNT_WIDTH=2 so saturation is reachable).
module tb_param_sequence_detector;

  logic       clk = 1'b0;
  logic       resetn;
  logic       seq;
  logic       valid;
  logic       cfg_load;
  logic [4:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic       cfg_err;
  logic       detected;
  logic [1:0] match_count;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_cnt = 2'd0;

  param_sequence_detector #(
    .PATTERN_WIDTH  (5),
    .DEFAULT_PATTERN(5'b10110),
    .COUNT_WIDTH    (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .seq        (seq),
    .valid      (valid),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_err    (cfg_err),
    .detected   (detected),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check_outs(input logic exp_det, input logic exp_err, input string tag);
    logic [1:0] exp_mc;
`ifdef SEQ_DET_MATCH_COUNT_EN
    exp_mc = exp_cnt;
`else
    exp_mc = 2'd0;
`endif
    checks++;
    assert (detected === exp_det) else begin
      errors++;
      $error("FAIL %s detected: got %b expected %b", tag, detected, exp_det);
    end
    checks++;
    assert (cfg_err === exp_err) else begin
      errors++;
      $error("FAIL %s cfg_err: got %b expected %b", tag, cfg_err, exp_err);
    end
    checks++;
    assert (match_count === exp_mc) else begin
      errors++;
      $error("FAIL %s match_count: got %0d expected %0d", tag, match_count, exp_mc);
    end
  endtask

  // One cycle of stream input; outputs checked 1 time unit after the edge.
  task automatic beat(input logic s, input logic v, input logic exp_det, input string tag);
    seq = s;
    valid = v;
    cfg_load = 1'b0;
    @(posedge clk);
    #1;
    if (exp_det && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
    check_outs(exp_det, 1'b0, tag);
  endtask

  task automatic load(input logic [4:0] pat, input logic [2:0] len, input logic ov,
                      input logic v, input logic exp_err, input string tag);
    cfg_load = 1'b1;
    cfg_pattern = pat;
    cfg_len = len;
    cfg_overlap = ov;
    valid = v;
    seq = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    valid = 1'b0;
    if (!exp_err) exp_cnt = 2'd0;
    check_outs(1'b0, exp_err, tag);
  endtask

  task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n,
                        input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      beat(bits[i], 1'b1, exp[i], tag);
    end
  endtask

  initial begin
    resetn = 1'b0;
    seq = 1'b1;
    valid = 1'b1;
    cfg_load = 1'b0;
    cfg_pattern = 5'b0;
    cfg_len = 3'd0;
    cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs(1'b0, 1'b0, "reset");
    resetn = 1'b1;

    // Default overlapping 10110 on 10110110: pulses after beats 5 and 8.
    stream(16'b10110110, 16'b00001001, 8, "t1_overlap");

    // Non-overlapping: only beat 5 matches.
    load(5'b10110, 3'd5, 1'b0, 1'b0, 1'b0, "t2_load");
    stream(16'b10110110, 16'b00001000, 8, "t2_nonoverlap");

    // Back to overlapping default, two idle cycles between beats.
    load(5'b10110, 3'd5, 1'b1, 1'b0, 1'b0, "t3_load");
    begin
      logic [4:0] pat3;
      pat3 = 5'b10110;
      for (int i = 4; i >= 0; i--) begin
        beat(pat3[i], 1'b1, (i == 0), "t3_beat");
        beat(1'b0, 1'b0, 1'b0, "t3_gap");
        beat(1'b1, 1'b0, 1'b0, "t3_gap");
      end
    end

    // Mid-stream reload to 111/len3 clears history; later illegal loads keep config.
    stream(16'b1011, 16'b0000, 4, "t4_pre");
    load(5'b00111, 3'd3, 1'b1, 1'b0, 1'b0, "t4_load");
    stream(16'b1111, 16'b0011, 4, "t4_111");
    load(5'b00000, 3'd0, 1'b0, 1'b0, 1'b1, "t4_len0");
    beat(1'b1, 1'b1, 1'b1, "t4_kept");
    load(5'b00000, 3'd6, 1'b0, 1'b1, 1'b1, "t4_len6");
    beat(1'b1, 1'b1, 1'b1, "t4_kept6");

    // Load with a same-cycle beat: the beat is dropped, three fresh 1s needed.
    load(5'b00111, 3'd3, 1'b1, 1'b1, 1'b0, "t4_dropload");
    stream(16'b111, 16'b001, 3, "t4_drop");

    // len=1, upper pattern bits ignored: match on every 0.
    load(5'b11110, 3'd1, 1'b1, 1'b0, 1'b0, "len1_load");
    stream(16'b0101, 16'b1010, 4, "len1");

    // Reset mid-stream restores default config and clears history.
    load(5'b00111, 3'd3, 1'b0, 1'b0, 1'b0, "t5_load");
    stream(16'b1011, 16'b0000, 4, "t5_pre");
    resetn = 1'b0;
    beat(1'b1, 1'b1, 1'b0, "t5_reset");
    exp_cnt = 2'd0;
    resetn = 1'b1;
    beat(1'b0, 1'b1, 1'b0, "t5_after");
    stream(16'b10110110, 16'b00001001, 8, "t5_default");

    // Counter saturation and clear on legal load.
    load(5'b10110, 3'd5, 1'b1, 1'b0, 1'b0, "t6_load");
    stream(16'b1011011011011011, 16'b0000100100100100, 16, "t6_count");
    stream(16'b0, 16'b1, 1, "t6_count5");
    load(5'b10110, 3'd5, 1'b1, 1'b0, 1'b0, "t6_clear");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
